// File: rtl/plle2_sequencer.sv
// Power/reset sequencer for one PLLE2: drives RST/PWRDWN/CLKINSEL, waits for a
// settled LOCKED with timeout and bounded retry, and recovers from lock loss.
module plle2_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 255,
  parameter int MAX_RETRIES   = 3
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       I_PWRDWN,
  input  logic       I_CLKINSEL,
  input  logic       I_RESTART,
  input  logic       I_LOCKED,
  output logic       O_PLL_RST,
  output logic       O_PLL_PWRDWN,
  output logic       O_PLL_CLKINSEL,
  output logic       O_READY,
  output logic       O_ERROR,
  output logic [2:0] O_STATE,
  output logic [3:0] O_RETRIES,
  output logic [7:0] O_LOSS_CNT
);

  localparam int TMAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int TMAX   = (TMAX_A > SETTLE_CYCLES) ? TMAX_A : SETTLE_CYCLES;
  localparam int TMR_W  = $clog2(TMAX + 1);

  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PWRDN     = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       retries_q, retries_d;
  logic [7:0]       loss_q, loss_d;
  logic             clksel_q, clksel_d;
  logic             lock_meta_q, locked_s;
  logic             enter;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic rst_held(input state_e s);
    return (s == ST_PWRDN) || (s == ST_RESET);
  endfunction

  // LOCKED comes from the PLL's own domain; two flops before any decision.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      lock_meta_q <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      lock_meta_q <= I_LOCKED;
      locked_s    <= lock_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    retries_d = retries_q;
    loss_d    = loss_q;
    enter     = 1'b0;
    if (I_PWRDWN) begin
      state_d = ST_PWRDN;
      enter   = (state_q != ST_PWRDN);
    end else if (I_RESTART) begin
      state_d   = ST_RESET;
      retries_d = 4'd0;
      enter     = 1'b1;
    end else begin
      unique case (state_q)
        ST_PWRDN: begin
          state_d   = ST_RESET;
          retries_d = 4'd0;
          enter     = 1'b1;
        end
        ST_RESET: begin
          if (timer_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            enter   = 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_SETTLE;
            enter   = 1'b1;
          end else if (timer_q == TIMEOUT_LAST) begin
            retries_d = retries_q + 4'd1;
            state_d   = (retries_q + 4'd1 == RETRY_LIMIT) ? ST_FAIL : ST_RESET;
            enter     = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!locked_s) begin
            state_d = ST_RESET;
            enter   = 1'b1;
          end else if (timer_q == SETTLE_LAST) begin
            state_d   = ST_RUN;
            retries_d = 4'd0;
            enter     = 1'b1;
          end
        end
        ST_RUN: begin
          if (!locked_s) begin
            state_d = ST_RESET;
            loss_d  = sat_inc8(loss_q);
            enter   = 1'b1;
          end else if (I_CLKINSEL != clksel_q) begin
            state_d = ST_RESET;
            enter   = 1'b1;
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: begin
          state_d = ST_RESET;
          enter   = 1'b1;
        end
      endcase
    end
    timer_d = enter ? '0 : timer_q + 1'b1;
    // Follow the request only when RST is high both before and after this edge,
    // so CLKINSEL never moves on the same edge that RST rises or falls.
    clksel_d = clksel_q;
    if (rst_held(state_q) && rst_held(state_d)) begin
      clksel_d = I_CLKINSEL;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= ST_RESET;
      timer_q      <= '0;
      retries_q    <= 4'd0;
      loss_q       <= 8'd0;
      clksel_q     <= 1'b0;
      O_PLL_RST    <= 1'b1;
      O_PLL_PWRDWN <= 1'b0;
      O_READY      <= 1'b0;
      O_ERROR      <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retries_q    <= retries_d;
      loss_q       <= loss_d;
      clksel_q     <= clksel_d;
      O_PLL_RST    <= rst_held(state_d) || (state_d == ST_FAIL);
      O_PLL_PWRDWN <= (state_d == ST_PWRDN);
      O_READY      <= (state_d == ST_RUN);
      O_ERROR      <= (state_d == ST_FAIL);
    end
  end

  assign O_STATE        = state_q;
  assign O_RETRIES      = retries_q;
  assign O_LOSS_CNT     = loss_q;
  assign O_PLL_CLKINSEL = clksel_q;

endmodule

// File: tb/tb_plle2_sequencer.sv
// Directed bench for plle2_sequencer: reset, lock, retry/fail, lock loss,
// clock-select switch, power-down priority and asynchronous reset.
module tb_plle2_sequencer;

  logic       clk = 1'b0;
  logic       rstn, pwrdwn, clkinsel, restart, locked;
  logic       pll_rst, pll_pwrdwn, pll_clkinsel, ready, error;
  logic [2:0] state;
  logic [3:0] retries;
  logic [7:0] loss_cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  plle2_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(20), .SETTLE_CYCLES(8), .MAX_RETRIES(2)
  ) dut (
    .CLK(clk), .RSTN(rstn), .I_PWRDWN(pwrdwn), .I_CLKINSEL(clkinsel),
    .I_RESTART(restart), .I_LOCKED(locked), .O_PLL_RST(pll_rst),
    .O_PLL_PWRDWN(pll_pwrdwn), .O_PLL_CLKINSEL(pll_clkinsel), .O_READY(ready),
    .O_ERROR(error), .O_STATE(state), .O_RETRIES(retries), .O_LOSS_CNT(loss_cnt)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_state"}, 32'(state), 1);
    chk({tag, "_rst"}, 32'(pll_rst), 1);
    chk({tag, "_pwrdwn"}, 32'(pll_pwrdwn), 0);
    chk({tag, "_clksel"}, 32'(pll_clkinsel), 0);
    chk({tag, "_ready"}, 32'(ready), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_retries"}, 32'(retries), 0);
    chk({tag, "_loss"}, 32'(loss_cnt), 0);
  endtask

  initial begin
    rstn = 1'b1; pwrdwn = 1'b0; clkinsel = 1'b0; restart = 1'b0; locked = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk_reset_values("por");
    step(2);
    rstn = 1'b1;

    // 1: release, 4-cycle RST, lock, 8-cycle settle
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("s1_rst_high", 32'(pll_rst), 1);
      chk("s1_state_reset", 32'(state), 1);
    end
    step(1);
    chk("s1_rst_fall", 32'(pll_rst), 0);
    chk("s1_state_wait", 32'(state), 2);
    step(3);
    locked = 1'b1;
    step(2);
    chk("s1_sync_latency", 32'(state), 2);
    step(1);
    chk("s1_state_settle", 32'(state), 3);
    step(7);
    chk("s1_not_ready_yet", 32'(ready), 0);
    chk("s1_still_settle", 32'(state), 3);
    step(1);
    chk("s1_ready", 32'(ready), 1);
    chk("s1_state_run", 32'(state), 4);
    chk("s1_retries", 32'(retries), 0);

    // 3: one-cycle lock drop in RUN
    locked = 1'b0;
    step(1);
    locked = 1'b1;
    step(1);
    chk("s3_ready_hold", 32'(ready), 1);
    step(1);
    chk("s3_ready_fall", 32'(ready), 0);
    chk("s3_state_reset", 32'(state), 1);
    chk("s3_loss1", 32'(loss_cnt), 1);
    chk("s3_rst_rise", 32'(pll_rst), 1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("s3_rst_high", 32'(pll_rst), 1);
    end
    step(1);
    chk("s3_rst_fall", 32'(pll_rst), 0);
    chk("s3_state_wait", 32'(state), 2);
    step(1);
    chk("s3_state_settle", 32'(state), 3);
    step(8);
    chk("s3_relock_run", 32'(state), 4);
    chk("s3_relock_ready", 32'(ready), 1);
    for (int i = 0; i < 299; i++) begin
      locked = 1'b0;
      step(1);
      locked = 1'b1;
      step(2);
      chk("s3_loop_reset", 32'(state), 1);
      step(13);
      chk("s3_loop_run", 32'(state), 4);
    end
    chk("s3_loss_sat", 32'(loss_cnt), 255);
    chk("s3_loop_ready", 32'(ready), 1);

    // 4: clock-select switch in RUN
    clkinsel = 1'b1;
    step(1);
    chk("s4_state_reset", 32'(state), 1);
    chk("s4_ready_fall", 32'(ready), 0);
    chk("s4_rst_rise", 32'(pll_rst), 1);
    chk("s4_clksel_held", 32'(pll_clkinsel), 0);
    chk("s4_loss_same", 32'(loss_cnt), 255);
    step(1);
    chk("s4_clksel_new", 32'(pll_clkinsel), 1);
    chk("s4_rst_during_sel", 32'(pll_rst), 1);
    step(2);
    chk("s4_rst_still_high", 32'(pll_rst), 1);
    step(1);
    chk("s4_rst_fall", 32'(pll_rst), 0);
    chk("s4_state_wait", 32'(state), 2);
    chk("s4_clksel_kept", 32'(pll_clkinsel), 1);
    step(9);
    chk("s4_run_again", 32'(state), 4);
    chk("s4_loss_final", 32'(loss_cnt), 255);

    // 5: power-down from SETTLE, then PWRDWN beats RESTART
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("s5_restart_state", 32'(state), 1);
    chk("s5_restart_ready", 32'(ready), 0);
    step(5);
    chk("s5_state_settle", 32'(state), 3);
    pwrdwn = 1'b1;
    step(1);
    chk("s5_state_pwrdn", 32'(state), 0);
    chk("s5_pwrdwn_out", 32'(pll_pwrdwn), 1);
    chk("s5_rst_out", 32'(pll_rst), 1);
    chk("s5_ready_low", 32'(ready), 0);
    clkinsel = 1'b0;
    step(1);
    chk("s5_clksel_in_pwrdn", 32'(pll_clkinsel), 0);
    chk("s5_still_pwrdn", 32'(state), 0);
    pwrdwn = 1'b0;
    step(1);
    chk("s5_exit_state", 32'(state), 1);
    chk("s5_exit_pwrdwn", 32'(pll_pwrdwn), 0);
    chk("s5_exit_rst", 32'(pll_rst), 1);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("s5_rst_high", 32'(pll_rst), 1);
    end
    step(1);
    chk("s5_rst_fall", 32'(pll_rst), 0);
    step(1);
    chk("s5_settle_again", 32'(state), 3);
    pwrdwn = 1'b1;
    restart = 1'b1;
    step(1);
    chk("s5_pwrdn_wins", 32'(state), 0);
    chk("s5_pwrdn_wins_out", 32'(pll_pwrdwn), 1);
    restart = 1'b0;
    step(1);
    chk("s5_pwrdn_hold", 32'(state), 0);

    // 2: no lock -> two timed-out attempts -> FAIL -> restart
    pwrdwn = 1'b0;
    locked = 1'b0;
    step(1);
    chk("s2_state_reset", 32'(state), 1);
    chk("s2_retries0", 32'(retries), 0);
    step(4);
    chk("s2_wait1", 32'(state), 2);
    chk("s2_rst_low1", 32'(pll_rst), 0);
    step(19);
    chk("s2_wait1_end", 32'(state), 2);
    step(1);
    chk("s2_retry_reset", 32'(state), 1);
    chk("s2_retries1", 32'(retries), 1);
    chk("s2_rst_high", 32'(pll_rst), 1);
    step(4);
    chk("s2_wait2", 32'(state), 2);
    step(19);
    chk("s2_wait2_end", 32'(state), 2);
    step(1);
    chk("s2_state_fail", 32'(state), 5);
    chk("s2_retries2", 32'(retries), 2);
    chk("s2_error", 32'(error), 1);
    chk("s2_fail_rst", 32'(pll_rst), 1);
    step(3);
    chk("s2_fail_stays", 32'(state), 5);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk("s2_restart_state", 32'(state), 1);
    chk("s2_restart_retries", 32'(retries), 0);
    chk("s2_restart_error", 32'(error), 0);

    // 6: asynchronous reset during WAIT_LOCK with one retry recorded
    step(4);
    chk("s6_wait1", 32'(state), 2);
    step(20);
    chk("s6_retry_reset", 32'(state), 1);
    chk("s6_retries1", 32'(retries), 1);
    step(4);
    chk("s6_wait2", 32'(state), 2);
    step(2);
    #3;
    rstn = 1'b0;
    #1;
    chk_reset_values("s6_async");
    step(1);
    chk("s6_held_state", 32'(state), 1);
    rstn = 1'b1;
    step(1);
    chk("s6_resume_state", 32'(state), 1);
    chk("s6_resume_rst", 32'(pll_rst), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
